fpu_arbiter: RTL and testbench

- Shares one fpu instance between N_REQ independent requesters.
- Grants one requester at a time, round-robin.
- Sequences the FPU start/valid handshake, returns the result to the granted requester, and recovers a hung FPU through a watchdog and a reset pulse.
- Sits between the issuing units and the fpu's start/i_signed/input_a/input_b/o_* interface.

---
 rtl/fpu_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between N_REQ requesters. It sequences
// the start/valid handshake, returns results, and recovers a hung FPU through
// a watchdog.
module fpu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int RECOVER_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 fpu_rst,
    output logic                 fpu_start,
    output logic [2:0]           fpu_op,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    input  logic                 fpu_busy,
    input  logic                 fpu_valid,
    input  logic                 fpu_err,
    input  logic [31:0]          fpu_result,
    input  logic [3:0]           fpu_flags
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP, RECOVER} state_t;

    state_t             state_r, state_nxt;
    logic [PW-1:0]      ptr_r, ptr_nxt;
    logic [PW-1:0]      gnt_r, gnt_nxt;
    logic [WW-1:0]      wdog_r, wdog_nxt;
    logic [RW-1:0]      rec_r, rec_nxt;
    logic               tmo_r, tmo_nxt;
    logic [N_REQ-1:0]   ack_r, ack_nxt;
    logic [N_REQ-1:0]   done_r, done_nxt;
    logic [31:0]        res_r, res_nxt;
    logic [3:0]         flags_r, flags_nxt;
    logic               err_r, err_nxt;
    logic               start_r, start_nxt;
    logic               frst_r, frst_nxt;
    logic [2:0]         op_r, op_nxt;
    logic [31:0]        a_r, a_nxt;
    logic [31:0]        b_r, b_nxt;

    logic [N_REQ-1:0]   rot_s;
    logic               win_found_s;
    logic [PW-1:0]      win_idx_s;
    logic [PW:0]        sum_s;
    logic [2:0]         win_op_s;
    logic [31:0]        win_a_s;
    logic [31:0]        win_b_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin winner: rotate requests so ptr sits at bit 0, take the first set bit.
    always_comb begin
        rot_s       = N_REQ'({req, req} >> ptr_r);
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s       = {1'b0, ptr_r} + (PW+1)'(k);
            sum_s       = (sum_s >= (PW+1)'(N_REQ)) ? sum_s - (PW+1)'(N_REQ) : sum_s;
            win_idx_s   = (!win_found_s && rot_s[k]) ? sum_s[PW-1:0] : win_idx_s;
            win_found_s = win_found_s | rot_s[k];
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        win_op_s = 3'b000;
        win_a_s  = 32'h0000_0000;
        win_b_s  = 32'h0000_0000;
        for (int i = 0; i < N_REQ; i++) begin
            win_op_s = (win_idx_s == PW'(i)) ? req_op[3*i +: 3]  : win_op_s;
            win_a_s  = (win_idx_s == PW'(i)) ? req_a[32*i +: 32] : win_a_s;
            win_b_s  = (win_idx_s == PW'(i)) ? req_b[32*i +: 32] : win_b_s;
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nxt = state_r;
        ptr_nxt   = ptr_r;
        gnt_nxt   = gnt_r;
        wdog_nxt  = wdog_r;
        rec_nxt   = rec_r;
        tmo_nxt   = tmo_r;
        ack_nxt   = '0;
        done_nxt  = '0;
        res_nxt   = res_r;
        flags_nxt = flags_r;
        err_nxt   = err_r;
        start_nxt = start_r;
        frst_nxt  = frst_r;
        op_nxt    = op_r;
        a_nxt     = a_r;
        b_nxt     = b_r;
        case (state_r)
            IDLE: begin
                if (win_found_s && !fpu_busy) begin
                    ack_nxt   = onehot(win_idx_s);
                    gnt_nxt   = win_idx_s;
                    op_nxt    = win_op_s;
                    a_nxt     = win_a_s;
                    b_nxt     = win_b_s;
                    start_nxt = 1'b1;
                    wdog_nxt  = '0;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                wdog_nxt = wdog_r + WW'(1);
                if (fpu_valid) begin
                    res_nxt   = fpu_result;
                    flags_nxt = fpu_flags;
                    err_nxt   = fpu_err;
                    tmo_nxt   = 1'b0;
                    start_nxt = 1'b0;
                    done_nxt  = onehot(gnt_r);
                    ptr_nxt   = (gnt_r == PW'(N_REQ - 1)) ? '0 : gnt_r + PW'(1);
                    state_nxt = RESP;
                end else if (wdog_r == WW'(TIMEOUT_CYC - 1)) begin
                    res_nxt   = 32'h0000_0000;
                    flags_nxt = 4'b0000;
                    err_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                    start_nxt = 1'b0;
                    done_nxt  = onehot(gnt_r);
                    ptr_nxt   = (gnt_r == PW'(N_REQ - 1)) ? '0 : gnt_r + PW'(1);
                    state_nxt = RESP;
                end else begin
                    state_nxt = RUN;
                end
            end
            RESP: begin
                // A timed-out FPU gets reset before anyone else is granted.
                if (tmo_r) begin
                    frst_nxt  = 1'b1;
                    rec_nxt   = '0;
                    state_nxt = RECOVER;
                end else if (!fpu_valid && !fpu_busy) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            RECOVER: begin
                if (rec_r == RW'(RECOVER_CYC - 1)) begin
                    frst_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    rec_nxt   = rec_r + RW'(1);
                    state_nxt = RECOVER;
                end
            end
            default: begin
                start_nxt = 1'b0;
                frst_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            gnt_r   <= '0;
            wdog_r  <= '0;
            rec_r   <= '0;
            tmo_r   <= 1'b0;
            ack_r   <= '0;
            done_r  <= '0;
            res_r   <= 32'h0000_0000;
            flags_r <= 4'b0000;
            err_r   <= 1'b0;
            start_r <= 1'b0;
            frst_r  <= 1'b0;
            op_r    <= 3'b000;
            a_r     <= 32'h0000_0000;
            b_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt;
            ptr_r   <= ptr_nxt;
            gnt_r   <= gnt_nxt;
            wdog_r  <= wdog_nxt;
            rec_r   <= rec_nxt;
            tmo_r   <= tmo_nxt;
            ack_r   <= ack_nxt;
            done_r  <= done_nxt;
            res_r   <= res_nxt;
            flags_r <= flags_nxt;
            err_r   <= err_nxt;
            start_r <= start_nxt;
            frst_r  <= frst_nxt;
            op_r    <= op_nxt;
            a_r     <= a_nxt;
            b_r     <= b_nxt;
        end
    end

    assign ack         = ack_r;
    assign done        = done_r;
    assign rsp_result  = res_r;
    assign rsp_flags   = flags_r;
    assign rsp_err     = err_r;
    assign rsp_timeout = tmo_r;
    assign fpu_rst     = frst_r;
    assign fpu_start   = start_r;
    assign fpu_op      = op_r;
    assign fpu_a       = a_r;
    assign fpu_b       = b_r;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small behavioural FPU model
// (fixed 5-cycle latency, optional hang, optional fixed result/error).
module tb_fpu_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [11:0]   req_op;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    ack;
    logic [3:0]    done;
    logic [31:0]   rsp_result;
    logic [3:0]    rsp_flags;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          fpu_rst;
    logic          fpu_start;
    logic [2:0]    fpu_op;
    logic [31:0]   fpu_a;
    logic [31:0]   fpu_b;
    logic          fpu_busy;
    logic          fpu_valid;
    logic          fpu_err;
    logic [31:0]   fpu_result;
    logic [3:0]    fpu_flags;

    // FPU model controls
    logic          mdl_xor;
    logic          mdl_never;
    logic          mdl_err;
    logic [31:0]   mdl_result;
    logic [3:0]    mdl_flags;
    logic          busy_force;
    int            run_cnt = 0;

    int            n_chk  = 0;
    int            n_pass = 0;

    logic [127:0]  all_out;
    assign all_out = {13'd0, ack, done, rsp_result, rsp_flags, rsp_err, rsp_timeout,
                      fpu_rst, fpu_start, fpu_op, fpu_a, fpu_b};

    fpu_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16), .RECOVER_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .ack(ack), .done(done), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .fpu_rst(fpu_rst),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_busy(fpu_busy), .fpu_valid(fpu_valid), .fpu_err(fpu_err),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags)
    );

    always #5 clk = ~clk;

    // FPU model: valid in the 5th cycle of start being high, unless hung.
    always @(posedge clk) run_cnt <= (fpu_start && !fpu_rst) ? run_cnt + 1 : 0;
    assign fpu_valid  = fpu_start && !fpu_rst && !mdl_never && (run_cnt == 4);
    assign fpu_result = mdl_xor ? (fpu_a ^ fpu_b) : mdl_result;
    assign fpu_err    = mdl_err;
    assign fpu_flags  = mdl_flags;
    assign fpu_busy   = busy_force;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops();
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3]  = 3'(i + 1);
            req_a[32*i +: 32] = 32'h1111_1111 * (i + 1);
            req_b[32*i +: 32] = 32'h0f0f_0f00 + 32'(i);
        end
    endtask

    function automatic logic [31:0] exp_res(input int i);
        return req_a[32*i +: 32] ^ req_b[32*i +: 32];
    endfunction

    task automatic expect_ack(input string tag, input logic [3:0] exp);
        for (int n = 0; n < 40 && ack == 4'b0000; n++) @(negedge clk);
        check_eq(tag, 128'(ack), 128'(exp));
    endtask

    task automatic expect_done(input string tag, input logic [3:0] exp);
        logic saw_ack;
        saw_ack = 1'b0;
        for (int n = 0; n < 40 && done == 4'b0000; n++) begin
            @(negedge clk);
            if (ack != 4'b0000) saw_ack = 1'b1;
        end
        check_eq(tag, 128'(done), 128'(exp));
        check_eq({tag, "_no_ack_before_done"}, 128'(saw_ack), 128'(1'b0));
    endtask

    initial begin
        int cnt;
        int n;
        int seq[5] = '{0, 1, 2, 3, 0};
        logic any;

        rst = 1'b0; req = 4'b0000; req_op = '0; req_a = '0; req_b = '0;
        mdl_xor = 1'b1; mdl_never = 1'b0; mdl_err = 1'b0;
        mdl_result = 32'h0; mdl_flags = 4'b0000; busy_force = 1'b0;
        set_ops();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", all_out, 128'd0);

        // Single request, no contention
        rst = 1'b1;
        req_op[2:0] = 3'b000; req_a[31:0] = 32'h3fc0_0000; req_b[31:0] = 32'h3fc0_0000;
        mdl_xor = 1'b0; mdl_result = 32'h4040_0000;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check_eq("t1_ack", 128'(ack), 128'(4'b0001));
        check_eq("t1_fpu_a", 128'(fpu_a), 128'(32'h3fc0_0000));
        req = 4'b0000;
        cnt = 0;
        while (fpu_start && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("t1_start_len", 128'(cnt), 128'(5));
        check_eq("t1_done", 128'(done), 128'(4'b0001));
        check_eq("t1_result", 128'(rsp_result), 128'(32'h4040_0000));
        check_eq("t1_err", 128'(rsp_err), 128'(1'b0));
        @(negedge clk);
        check_eq("t1_done_pulse", 128'(done), 128'(4'b0000));
        check_eq("t1_result_hold", 128'(rsp_result), 128'(32'h4040_0000));

        // Simultaneous requests from reset
        rst = 1'b0; req = 4'b1111; set_ops(); mdl_xor = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_ack("t2_ack", 4'(1 << seq[k]));
            check_eq("t2_op", 128'(fpu_op), 128'(seq[k] + 1));
            if (k == 4) req = 4'b0000;
            expect_done("t2_done", 4'(1 << seq[k]));
            check_eq("t2_result", 128'(rsp_result), 128'(exp_res(seq[k])));
        end

        // Round-robin skip: grant 1 moves ptr to 2, then 0 wins by wrap
        req = 4'b0010;
        expect_ack("t3_ack1", 4'b0010);
        req = 4'b0000;
        expect_done("t3_done1", 4'b0010);
        req = 4'b0011;
        expect_ack("t3_ack_wrap", 4'b0001);
        req = 4'b0010;
        expect_done("t3_done_wrap", 4'b0001);
        expect_ack("t3_ack_next", 4'b0010);
        req = 4'b0000;
        expect_done("t3_done_next", 4'b0010);
        check_eq("t3_result", 128'(rsp_result), 128'(exp_res(1)));

        // FPU error passthrough
        mdl_xor = 1'b0; mdl_err = 1'b1; mdl_flags = 4'b1000; mdl_result = 32'h7fc0_0000;
        req = 4'b0100;
        expect_ack("t4_ack", 4'b0100);
        req = 4'b0000;
        expect_done("t4_done", 4'b0100);
        check_eq("t4_err", 128'(rsp_err), 128'(1'b1));
        check_eq("t4_timeout", 128'(rsp_timeout), 128'(1'b0));
        check_eq("t4_flags", 128'(rsp_flags), 128'(4'b1000));
        check_eq("t4_result", 128'(rsp_result), 128'(32'h7fc0_0000));
        mdl_xor = 1'b1; mdl_err = 1'b0; mdl_flags = 4'b0000;

        // Watchdog: ptr=3, so 0 wins; 2 stays pending through recovery
        mdl_never = 1'b1;
        req = 4'b0101;
        expect_ack("t5_ack", 4'b0001);
        req = 4'b0100;
        cnt = 0;
        while (fpu_start && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("t5_start_len", 128'(cnt), 128'(16));
        check_eq("t5_done", 128'(done), 128'(4'b0001));
        check_eq("t5_err", 128'(rsp_err), 128'(1'b1));
        check_eq("t5_timeout", 128'(rsp_timeout), 128'(1'b1));
        check_eq("t5_result", 128'(rsp_result), 128'(32'h0));
        n = 0;
        while (!fpu_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
        cnt = 0;
        while (fpu_rst && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("t5_fpu_rst_len", 128'(cnt), 128'(2));
        mdl_never = 1'b0;
        expect_ack("t5_ack_after", 4'b0100);
        req = 4'b0000;
        expect_done("t5_done_after", 4'b0100);
        check_eq("t5_result_after", 128'(rsp_result), 128'(exp_res(2)));

        // Reset mid-operation
        mdl_never = 1'b1;
        req = 4'b0010;
        expect_ack("t6_ack", 4'b0010);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_reset_outputs", all_out, 128'd0);
        rst = 1'b1; mdl_never = 1'b0;
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done != 4'b0000) any = 1'b1;
        end
        check_eq("t6_no_done", 128'(any), 128'(1'b0));
        // No grant while the FPU reports busy
        busy_force = 1'b1;
        req = 4'b1001;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack != 4'b0000) any = 1'b1;
        end
        check_eq("t6_busy_hold", 128'(any), 128'(1'b0));
        busy_force = 1'b0;
        expect_ack("t6_ack_ptr0", 4'b0001);
        req = 4'b1000;
        expect_done("t6_done0", 4'b0001);
        check_eq("t6_result0", 128'(rsp_result), 128'(exp_res(0)));
        expect_ack("t6_ack3", 4'b1000);
        req = 4'b0000;
        expect_done("t6_done3", 4'b1000);
        check_eq("t6_result3", 128'(rsp_result), 128'(exp_res(3)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
